alu_result_uart_tx: RTL and testbench

Downstream consumer of the ALU result bus. Captures the ALU result whenever the core strobes `capture` and queues it in a small FIFO. Serialises each queued word over the board UART TX line as 8N1 bytes, least-significant byte first. Gives the single-cycle core a non-blocking debug/trace path: the core never stalls, and overflowing results are counted, not queued.

---
 rtl/alu_result_uart_tx_pkg.sv | 23 ++
 rtl/alu_result_uart_tx_fifo.sv | 68 ++++++
 rtl/alu_result_uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_alu_result_uart_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_uart_tx_pkg.sv
// Shared definitions for the ALU result UART trace path.
//   - uart_state_t : transmit FSM state encoding
//   - START_BIT / STOP_BIT / DATA_BITS : 8N1 frame constants
//   - bytes_of()   : number of UART bytes needed for a result word
package alu_result_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // Bytes needed to carry a word of the given width (ceiling divide).
    function automatic int bytes_of(input int length);
        return (length + DATA_BITS - 1) / DATA_BITS;
    endfunction

endpackage

// File: rtl/alu_result_uart_tx_fifo.sv
// result_fifo: DEPTH x LENGTH queue of captured ALU results.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data; accepted when not full, or when a
//                pop happens in the same cycle
//   pop, dout  : read request; dout always shows the registered head entry
//   full/empty : decoded from the registered occupancy count
module result_fifo
    import alu_result_uart_tx_pkg::*;
#(
    parameter int LENGTH = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [LENGTH-1:0] din,
    output logic [LENGTH-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);

    logic [LENGTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic              do_pop_s;
    logic              do_push_s;

    // Accept decisions; a pop frees a slot for a push in the same cycle.
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != COUNT_FULL) || do_pop_s);
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == COUNT_FULL);
    assign empty = (count_r == '0);

endmodule

// File: rtl/alu_result_uart_tx.sv
// alu_result_uart_tx: captures ALU results into a small FIFO and sends each
// word over a UART TX line as 8N1 bytes, least-significant byte first.
//   clk, rst_n : clock, asynchronous active-low reset
//   capture    : one-cycle strobe, samples result on this edge
//   result     : ALU result word
//   tx         : registered UART line, idles high
//   busy       : FIFO non-empty or frame in flight
//   full/empty : FIFO status
//   drop_cnt   : saturating count of captures rejected because FIFO was full
module alu_result_uart_tx
    import alu_result_uart_tx_pkg::*;
#(
    parameter int LENGTH       = 5,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture,
    input  logic [LENGTH-1:0] result,
    output logic              tx,
    output logic              busy,
    output logic              full,
    output logic              empty,
    output logic [7:0]        drop_cnt
);

    localparam int BYTES  = bytes_of(LENGTH);
    localparam int WORD_W = DATA_BITS * BYTES;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

    uart_state_t       state_r,  state_nxt;
    logic [BAUD_W-1:0] baud_r,   baud_nxt;
    logic [2:0]        bit_r,    bit_nxt;
    logic [BYTE_W-1:0] byte_r,   byte_nxt;
    logic [WORD_W-1:0] word_r,   word_nxt;
    logic [7:0]        shift_r,  shift_nxt;
    logic              tx_r,     tx_nxt;
    logic [7:0]        drop_r,   drop_nxt;

    logic              fifo_pop_s;
    logic [LENGTH-1:0] fifo_dout_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              baud_done_s;
    logic [WORD_W-1:0] word_load_s;
    logic [BYTE_W-1:0] byte_next_s;
    logic [WORD_W-1:0] word_shift_s;

    result_fifo #(
        .LENGTH (LENGTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture),
        .pop   (fifo_pop_s),
        .din   (result),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Helpers: zero-extended head word and the next byte of the word in flight.
    always_comb begin
        baud_done_s  = (baud_r == BAUD_LAST);
        word_load_s  = WORD_W'(fifo_dout_s);
        byte_next_s  = byte_r + BYTE_W'(1);
        word_shift_s = word_r >> {byte_next_s, 3'b000};
    end

    // Transmit FSM next-state, baud/bit/byte counters and drop counter.
    always_comb begin
        state_nxt  = state_r;
        baud_nxt   = baud_r;
        bit_nxt    = bit_r;
        byte_nxt   = byte_r;
        word_nxt   = word_r;
        shift_nxt  = shift_r;
        tx_nxt     = tx_r;
        drop_nxt   = drop_r;
        fifo_pop_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    // Start bit is driven on the same edge as the pop.
                    fifo_pop_s = 1'b1;
                    word_nxt   = word_load_s;
                    shift_nxt  = word_load_s[7:0];
                    byte_nxt   = '0;
                    bit_nxt    = 3'd0;
                    baud_nxt   = '0;
                    tx_nxt     = START_BIT;
                    state_nxt  = ST_START;
                end else begin
                    tx_nxt = STOP_BIT;
                end
            end
            ST_START: begin
                if (baud_done_s) begin
                    baud_nxt  = '0;
                    tx_nxt    = shift_r[0];
                    state_nxt = ST_DATA;
                end else begin
                    baud_nxt = baud_r + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done_s) begin
                    baud_nxt = '0;
                    if (bit_r == 3'd7) begin
                        bit_nxt   = 3'd0;
                        tx_nxt    = STOP_BIT;
                        state_nxt = ST_STOP;
                    end else begin
                        bit_nxt   = bit_r + 3'd1;
                        shift_nxt = {1'b0, shift_r[7:1]};
                        tx_nxt    = shift_r[1];
                    end
                end else begin
                    baud_nxt = baud_r + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_done_s) begin
                    baud_nxt = '0;
                    if (byte_r == BYTE_LAST) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        // Next byte follows the stop bit with no idle gap.
                        byte_nxt  = byte_next_s;
                        shift_nxt = word_shift_s[7:0];
                        tx_nxt    = START_BIT;
                        state_nxt = ST_START;
                    end
                end else begin
                    baud_nxt = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = STOP_BIT;
            end
        endcase

        // A capture is lost only if the FIFO is full and nothing is popped.
        if (capture && fifo_full_s && !fifo_pop_s && (drop_r != 8'hFF)) begin
            drop_nxt = drop_r + 8'd1;
        end else begin
            drop_nxt = drop_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            baud_r  <= '0;
            bit_r   <= 3'd0;
            byte_r  <= '0;
            word_r  <= '0;
            shift_r <= 8'h00;
            tx_r    <= STOP_BIT;
            drop_r  <= 8'h00;
        end else begin
            state_r <= state_nxt;
            baud_r  <= baud_nxt;
            bit_r   <= bit_nxt;
            byte_r  <= byte_nxt;
            word_r  <= word_nxt;
            shift_r <= shift_nxt;
            tx_r    <= tx_nxt;
            drop_r  <= drop_nxt;
        end
    end

    assign tx       = tx_r;
    assign busy     = (state_r != ST_IDLE) || !fifo_empty_s;
    assign full     = fifo_full_s;
    assign empty    = fifo_empty_s;
    assign drop_cnt = drop_r;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
module tb_alu_result_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cap5 = 1'b0;
    logic [4:0]  res5 = 5'h00;
    logic        cap32 = 1'b0;
    logic [31:0] res32 = 32'h0;
    logic        tx5, busy5, full5, empty5;
    logic        tx32, busy32, full32, empty32;
    logic [7:0]  drop5, drop32;

    int checks = 0;
    int failures = 0;
    logic [7:0] q5[$];
    logic [7:0] q32[$];
    logic mon5_en = 1'b0;
    logic mon32_en = 1'b1;

    always #5 clk = ~clk;

    alu_result_uart_tx #(.LENGTH(5), .DEPTH(4), .CLKS_PER_BIT(4)) dut5 (
        .clk(clk), .rst_n(rst_n), .capture(cap5), .result(res5),
        .tx(tx5), .busy(busy5), .full(full5), .empty(empty5), .drop_cnt(drop5));

    alu_result_uart_tx #(.LENGTH(32), .DEPTH(4), .CLKS_PER_BIT(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .capture(cap32), .result(res32),
        .tx(tx32), .busy(busy32), .full(full32), .empty(empty32), .drop_cnt(drop32));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic sel_tx(input int which);
        return (which == 5) ? tx5 : tx32;
    endfunction

    // Called on the first negedge a start bit is seen; samples bit centres.
    task automatic rx_byte(input int which, output logic [7:0] b, output logic stop_bit);
        repeat (2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            repeat (4) @(negedge clk);
            b[j] = sel_tx(which);
        end
        repeat (4) @(negedge clk);
        stop_bit = sel_tx(which);
    endtask

    // Scoreboard monitor for the 5-bit instance.
    initial begin : mon5
        logic [7:0] b;
        logic       s;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (mon5_en && tx5 === 1'b0) begin
                rx_byte(5, b, s);
                checks++;
                if (q5.size() == 0) begin
                    failures++;
                    $display("FAIL rx5_unexpected got=%0h stop=%0b exp=none", b, s);
                end else begin
                    e = q5.pop_front();
                    if (b !== e || s !== 1'b1) begin
                        failures++;
                        $display("FAIL rx5_byte got=%0h stop=%0b exp=%0h stop=1", b, s, e);
                    end
                end
            end
        end
    end

    // Scoreboard monitor for the 32-bit instance.
    initial begin : mon32
        logic [7:0] b;
        logic       s;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (mon32_en && tx32 === 1'b0) begin
                rx_byte(32, b, s);
                checks++;
                if (q32.size() == 0) begin
                    failures++;
                    $display("FAIL rx32_unexpected got=%0h stop=%0b exp=none", b, s);
                end else begin
                    e = q32.pop_front();
                    if (b !== e || s !== 1'b1) begin
                        failures++;
                        $display("FAIL rx32_byte got=%0h stop=%0b exp=%0h stop=1", b, s, e);
                    end
                end
            end
        end
    end

    task automatic wait_idle5(input int limit);
        int n = 0;
        while (busy5 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle5_timeout", {31'd0, busy5}, 32'd0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        repeat (3) @(negedge clk);
        check("rst_tx5", {31'd0, tx5}, 32'd1);
        check("rst_empty5", {31'd0, empty5}, 32'd1);
        check("rst_full5", {31'd0, full5}, 32'd0);
        check("rst_busy5", {31'd0, busy5}, 32'd0);
        check("rst_drop5", {24'd0, drop5}, 32'd0);
        check("rst_tx32", {31'd0, tx32}, 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: reset in the middle of a data bit.
        cap5 = 1'b1; res5 = 5'h00;
        @(negedge clk);
        cap5 = 1'b0;
        repeat (12) @(negedge clk);
        check("t1_tx_low_mid_data", {31'd0, tx5}, 32'd0);
        check("t1_busy_mid_data", {31'd0, busy5}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t1_tx_reset", {31'd0, tx5}, 32'd1);
        check("t1_empty_reset", {31'd0, empty5}, 32'd1);
        check("t1_busy_reset", {31'd0, busy5}, 32'd0);
        check("t1_drop_reset", {24'd0, drop5}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        mon5_en = 1'b1;
        q5.push_back(8'h05);
        cap5 = 1'b1; res5 = 5'h05;
        @(negedge clk);
        cap5 = 1'b0;
        wait_idle5(200);
        repeat (3) @(negedge clk);

        // Test 3: 5-bit word, upper bits of the byte are zero; 40-cycle frame.
        q5.push_back(8'h16);
        cap5 = 1'b1; res5 = 5'b10110;
        @(posedge clk); #1;
        cap5 = 1'b0;
        check("t3_tx_at_capture", {31'd0, tx5}, 32'd1);
        @(posedge clk); #1;
        check("t3_tx_start", {31'd0, tx5}, 32'd0);
        n = 0;
        while (busy5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("t3_frame_len", n, 32'd40);
        repeat (3) @(negedge clk);

        // Test 2: 32-bit word, LSB first, 160 cycles from start to idle.
        q32.push_back(8'h78); q32.push_back(8'h56);
        q32.push_back(8'h34); q32.push_back(8'h12);
        cap32 = 1'b1; res32 = 32'h12345678;
        @(posedge clk); #1;
        cap32 = 1'b0;
        check("t2_tx_at_capture", {31'd0, tx32}, 32'd1);
        @(posedge clk); #1;
        check("t2_tx_start", {31'd0, tx32}, 32'd0);
        n = 0;
        while (busy32 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("t2_busy_len", n, 32'd160);
        repeat (3) @(negedge clk);

        // Test 4: six captures on consecutive edges; sixth dropped.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cap5 = 1'b1; res5 = 5'(i + 1);
            if (i < 5) q5.push_back(8'(i + 1));
            @(posedge clk); #1;
            if (i == 1) check("t4_first_popped", {31'd0, tx5}, 32'd0);
            if (i == 3) check("t4_not_full_at_3", {31'd0, full5}, 32'd0);
            if (i == 4) check("t4_full_after_5th", {31'd0, full5}, 32'd1);
            if (i == 5) begin
                check("t4_drop_6th", {24'd0, drop5}, 32'd1);
                check("t4_full_after_6th", {31'd0, full5}, 32'd1);
            end
        end
        @(negedge clk);
        cap5 = 1'b0;

        // Test 5: capture on the pop edge of the second word (41 cycles after first pop).
        repeat (36) @(posedge clk);
        #1;
        check("t5_tx_idle_gap", {31'd0, tx5}, 32'd1);
        check("t5_full_before", {31'd0, full5}, 32'd1);
        @(negedge clk);
        cap5 = 1'b1; res5 = 5'h07;
        q5.push_back(8'h07);
        @(posedge clk); #1;
        check("t5_pop_edge", {31'd0, tx5}, 32'd0);
        check("t5_full_kept", {31'd0, full5}, 32'd1);
        check("t5_drop_unchanged", {24'd0, drop5}, 32'd1);

        // Test 6: 300 captures while full; only pop edges (every 41) accept.
        @(negedge clk);
        res5 = 5'h1F;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            if (k % 41 == 0) q5.push_back(8'h1F);
        end
        @(negedge clk);
        cap5 = 1'b0;
        check("t6_drop_sat", {24'd0, drop5}, 32'd255);
        check("t6_full", {31'd0, full5}, 32'd1);
        wait_idle5(2000);
        repeat (5) @(negedge clk);
        check("t6_drop_hold", {24'd0, drop5}, 32'd255);
        check("end_empty5", {31'd0, empty5}, 32'd1);
        check("end_q5_drained", q5.size(), 32'd0);
        check("end_q32_drained", q32.size(), 32'd0);
        check("end_drop32", {24'd0, drop32}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
